// File: rtl/sumador_fixed_sched_if.sv
// rtl/sumador_fixed_sched_if.sv - requester, result and handshake bundle for the shared fixed-point adder
interface sumador_fixed_sched_if #(
    parameter int NBA = 16,
    parameter int NBB = 12,
    parameter int NBS = 9
);
    logic           i_valid0;
    logic [NBA-1:0] i_a0;
    logic [NBB-1:0] i_b0;
    logic           o_ready0;
    logic           i_valid1;
    logic [NBA-1:0] i_a1;
    logic [NBB-1:0] i_b1;
    logic           o_ready1;
    logic           o_valid;
    logic           i_ready;
    logic           o_id;
    logic [NBA:0]   o_sum_full;
    logic [NBS-1:0] o_sum_rnd;
    logic           o_sat;

    modport master (
        output i_valid0, i_a0, i_b0, i_valid1, i_a1, i_b1, i_ready,
        input  o_ready0, o_ready1, o_valid, o_id, o_sum_full, o_sum_rnd, o_sat
    );

    modport slave (
        input  i_valid0, i_a0, i_b0, i_valid1, i_a1, i_b1, i_ready,
        output o_ready0, o_ready1, o_valid, o_id, o_sum_full, o_sum_rnd, o_sat
    );
endinterface

// File: rtl/sumador_fixed_sched.sv
// rtl/sumador_fixed_sched.sv - round-robin shared registered S(16,14)+S(12,11) adder with round/saturate
module sumador_fixed_sched #(
    parameter int NBA  = 16,
    parameter int NBFA = 14,
    parameter int NBB  = 12,
    parameter int NBFB = 11,
    parameter int NBS  = 9,
    parameter int NBFS = 8
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    sumador_fixed_sched_if.slave  bus
);
    localparam int EXT  = (NBA - NBFA) - (NBB - NBFB);
    localparam int PAD  = NBFA - NBFB;
    localparam int SH   = NBFA - NBFS;
    localparam int NBR  = NBA + 2;
    localparam int HALF = 1 << (SH - 1);
    localparam logic signed [NBR-1:0] MAXV = NBR'((1 << (NBS - 1)) - 1);
    localparam logic signed [NBR-1:0] MINV = -NBR'(1 << (NBS - 1));

    typedef enum logic [1:0] {IDLE, ADD, OUT} state_t;

    state_t         st;
    logic           rr;
    logic [NBA-1:0] a_q;
    logic [NBB-1:0] b_q;
    logic           id_q;
    logic           valid_q;
    logic           oid_q;
    logic [NBA:0]   full_q;
    logic [NBS-1:0] rnd_q;
    logic           sat_q;

    logic           grant0, grant1;
    logic           ready0, ready1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.i_valid0 && bus.i_valid1) begin
            grant0 = ~rr;
            grant1 = rr;
        end else begin
            grant0 = bus.i_valid0;
            grant1 = bus.i_valid1;
        end
    end

    // Ready is gated by reset so nothing reads as accepted while reset is held.
    assign ready0 = i_rst_n & (st == IDLE) & grant0;
    assign ready1 = i_rst_n & (st == IDLE) & grant1;

    logic [NBA-1:0]        b_align;
    logic signed [NBA:0]   sum;
    logic signed [NBR-1:0] rsum;
    logic signed [NBR-1:0] rtr;
    logic                  sat_hi, sat_lo;
    logic [NBS-1:0]        rnd_val;

    // B gets the extra integer bit by sign extension and the missing fraction bits as zeros.
    assign b_align = {{EXT{b_q[NBB-1]}}, b_q, {PAD{1'b0}}};
    assign sum     = $signed({a_q[NBA-1], a_q}) + $signed({b_align[NBA-1], b_align});
    assign rsum    = $signed({sum[NBA], sum}) + $signed(NBR'(HALF));
    assign rtr     = rsum >>> SH;
    assign sat_hi  = rtr > MAXV;
    assign sat_lo  = rtr < MINV;
    assign rnd_val = sat_hi ? MAXV[NBS-1:0] : (sat_lo ? MINV[NBS-1:0] : rtr[NBS-1:0]);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st      <= IDLE;
            rr      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
            oid_q   <= 1'b0;
            full_q  <= '0;
            rnd_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.i_valid0 && ready0) begin
                        a_q  <= bus.i_a0;
                        b_q  <= bus.i_b0;
                        id_q <= 1'b0;
                        rr   <= 1'b1;
                        st   <= ADD;
                    end else if (bus.i_valid1 && ready1) begin
                        a_q  <= bus.i_a1;
                        b_q  <= bus.i_b1;
                        id_q <= 1'b1;
                        rr   <= 1'b0;
                        st   <= ADD;
                    end
                end
                ADD: begin
                    full_q  <= sum;
                    rnd_q   <= rnd_val;
                    sat_q   <= sat_hi | sat_lo;
                    oid_q   <= id_q;
                    valid_q <= 1'b1;
                    st      <= OUT;
                end
                OUT: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        st      <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.o_ready0   = ready0;
    assign bus.o_ready1   = ready1;
    assign bus.o_valid    = valid_q;
    assign bus.o_id       = oid_q;
    assign bus.o_sum_full = full_q;
    assign bus.o_sum_rnd  = rnd_q;
    assign bus.o_sat      = sat_q;
endmodule

// File: tb/tb_sumador_fixed_sched.sv
// tb/tb_sumador_fixed_sched.sv - vector table and scoreboard bench for sumador_fixed_sched
module tb_sumador_fixed_sched;
    logic clk = 1'b0;
    logic i_rst_n;
    always #5 clk = ~clk;

    sumador_fixed_sched_if bus ();
    sumador_fixed_sched dut (.clk(clk), .i_rst_n(i_rst_n), .bus(bus));

    typedef struct {
        logic        id;
        logic [16:0] full;
        logic [8:0]  rnd;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [11:0] b;
        logic [16:0] full;
        logic [8:0]  rnd;
        logic        sat;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   acc_q[$];
    logic accid_q[$];
    int   rise_q[$];
    exp_t pend0, pend1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic exp_t model(input logic id, input logic [15:0] a, input logic [11:0] b);
        exp_t e;
        int   s, r;
        s = int'($signed(a)) + int'($signed(b)) * 8;
        r = (s + 32) >>> 6;
        e.sat = 1'b0;
        if (r > 255) begin r = 255; e.sat = 1'b1; end
        if (r < -256) begin r = -256; e.sat = 1'b1; end
        e.id   = id;
        e.full = s[16:0];
        e.rnd  = r[8:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (i_rst_n) begin
            if (bus.i_valid0 && bus.o_ready0) begin
                acc_q.push_back(cyc); accid_q.push_back(1'b0); sb.push_back(pend0);
            end
            if (bus.i_valid1 && bus.o_ready1) begin
                acc_q.push_back(cyc); accid_q.push_back(1'b1); sb.push_back(pend1);
            end
            if (bus.o_valid && !prev_valid) rise_q.push_back(cyc);
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_id",   32'(bus.o_id),       32'(e.id));
                    chk("res_full", 32'(bus.o_sum_full), 32'(e.full));
                    chk("res_rnd",  32'(bus.o_sum_rnd),  32'(e.rnd));
                    chk("res_sat",  32'(bus.o_sat),      32'(e.sat));
                end
            end
        end
        prev_valid <= bus.o_valid;
    end

    task automatic raise(input logic id, input logic [15:0] a, input logic [11:0] b, input exp_t e);
        if (!id) begin
            bus.i_a0 = a; bus.i_b0 = b; pend0 = e; bus.i_valid0 = 1'b1;
        end else begin
            bus.i_a1 = a; bus.i_b1 = b; pend1 = e; bus.i_valid1 = 1'b1;
        end
    endtask

    task automatic wait_accept(input logic id, input string name);
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (id ? bus.o_ready1 : bus.o_ready0) break;
            n++;
        end
        if (n == 50) timeout(name);
        @(posedge clk); #1;
        if (!id) bus.i_valid0 = 1'b0; else bus.i_valid1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            timeout(name);
            sb.delete();
        end
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{16'h1000, 12'h200, 17'h02000, 9'h080, 1'b0};
        vt[1]  = '{16'h4000, 12'h400, 17'h06000, 9'h0FF, 1'b1};
        vt[2]  = '{16'h8000, 12'h800, 17'h14000, 9'h100, 1'b1};
        vt[3]  = '{16'h0020, 12'h000, 17'h00020, 9'h001, 1'b0};
        vt[4]  = '{16'h001F, 12'h000, 17'h0001F, 9'h000, 1'b0};
        vt[5]  = '{16'hFFE0, 12'h000, 17'h1FFE0, 9'h000, 1'b0};
        vt[6]  = '{16'h7FFF, 12'h7FF, 17'h0BFF7, 9'h0FF, 1'b1};
        vt[7]  = '{16'h0000, 12'hFFF, 17'h1FFF8, 9'h000, 1'b0};
        vt[8]  = '{16'h3FC0, 12'h000, 17'h03FC0, 9'h0FF, 1'b0};
        vt[9]  = '{16'h3FE0, 12'h000, 17'h03FE0, 9'h0FF, 1'b1};
        vt[10] = '{16'hBFE0, 12'h000, 17'h1BFE0, 9'h100, 1'b0};
        vt[11] = '{16'hBFDF, 12'h000, 17'h1BFDF, 9'h100, 1'b1};

        i_rst_n = 1'b0;
        bus.i_valid0 = 1'b1; bus.i_a0 = '0; bus.i_b0 = '0;
        bus.i_valid1 = 1'b0; bus.i_a1 = '0; bus.i_b1 = '0;
        bus.i_ready = 1'b1;
        #12;
        chk("rst_valid",  32'(bus.o_valid),    32'd0);
        chk("rst_ready0", 32'(bus.o_ready0),   32'd0);
        chk("rst_ready1", 32'(bus.o_ready1),   32'd0);
        chk("rst_full",   32'(bus.o_sum_full), 32'd0);
        chk("rst_rnd",    32'(bus.o_sum_rnd),  32'd0);
        chk("rst_sat_id", 32'({bus.o_sat, bus.o_id}), 32'd0);
        bus.i_valid0 = 1'b0;
        @(posedge clk); #2;
        i_rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            logic id;
            id = 1'(i % 2);
            raise(id, vt[i].a, vt[i].b, '{id, vt[i].full, vt[i].rnd, vt[i].sat});
            wait_accept(id, "table_accept");
            drain("table_drain");
        end

        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra;
            logic [11:0] rb;
            logic        id;
            ra = 16'($urandom);
            rb = 12'($urandom);
            id = 1'(i % 2);
            raise(id, ra, rb, model(id, ra, rb));
            wait_accept(id, "rand_accept");
            drain("rand_drain");
        end

        begin
            int abase, rbase, n0, n1, guard;
            logic g0, g1;
            logic [15:0] ra;
            logic [11:0] rb;
            abase = acc_q.size(); rbase = rise_q.size();
            n0 = 0; n1 = 0; guard = 0;
            ra = 16'($urandom); rb = 12'($urandom); raise(1'b0, ra, rb, model(1'b0, ra, rb));
            ra = 16'($urandom); rb = 12'($urandom); raise(1'b1, ra, rb, model(1'b1, ra, rb));
            while ((n0 < 4 || n1 < 4) && guard < 200) begin
                @(negedge clk);
                g0 = bus.o_ready0; g1 = bus.o_ready1;
                @(posedge clk); #1;
                guard++;
                if (g0) begin
                    n0++;
                    ra = 16'($urandom); rb = 12'($urandom);
                    if (n0 < 4) raise(1'b0, ra, rb, model(1'b0, ra, rb)); else bus.i_valid0 = 1'b0;
                end
                if (g1) begin
                    n1++;
                    ra = 16'($urandom); rb = 12'($urandom);
                    if (n1 < 4) raise(1'b1, ra, rb, model(1'b1, ra, rb)); else bus.i_valid1 = 1'b0;
                end
            end
            if (guard == 200) timeout("arb_loop");
            drain("arb_drain");
            if (acc_q.size() - abase < 8 || rise_q.size() - rbase < 8) begin
                timeout("arb_events");
            end else begin
                for (int k = 0; k < 8; k++) begin
                    chk("arb_id", 32'(accid_q[abase+k]), 32'(k % 2));
                    chk("arb_latency", 32'(rise_q[rbase+k] - acc_q[abase+k]), 32'd2);
                    if (k > 0) chk("arb_spacing", 32'(acc_q[abase+k] - acc_q[abase+k-1]), 32'd3);
                end
            end
        end

        begin
            int n;
            bus.i_ready = 1'b0;
            raise(1'b0, 16'h1000, 12'h200, '{1'b0, 17'h02000, 9'h080, 1'b0});
            wait_accept(1'b0, "bp_accept");
            raise(1'b1, 16'h4000, 12'h400, '{1'b1, 17'h06000, 9'h0FF, 1'b1});
            n = 0;
            while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
            if (n == 20) timeout("bp_valid");
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("bp_valid",  32'(bus.o_valid),    32'd1);
                chk("bp_full",   32'(bus.o_sum_full), 32'h02000);
                chk("bp_rnd",    32'(bus.o_sum_rnd),  32'h080);
                chk("bp_ready0", 32'(bus.o_ready0),   32'd0);
                chk("bp_ready1", 32'(bus.o_ready1),   32'd0);
            end
            @(posedge clk); #1;
            bus.i_ready = 1'b1;
            wait_accept(1'b1, "bp_pending_accept");
            drain("bp_drain");
        end

        raise(1'b0, 16'h4000, 12'h400, '{1'b0, 17'h06000, 9'h0FF, 1'b1});
        wait_accept(1'b0, "rst_accept");
        #2;
        i_rst_n = 1'b0;
        #1;
        if (sb.size() > 0) void'(sb.pop_back());
        chk("rstadd_valid", 32'(bus.o_valid),    32'd0);
        chk("rstadd_full",  32'(bus.o_sum_full), 32'd0);
        chk("rstadd_rnd",   32'(bus.o_sum_rnd),  32'd0);
        chk("rstadd_satid", 32'({bus.o_sat, bus.o_id}), 32'd0);
        raise(1'b0, 16'h0020, 12'h000, '{1'b0, 17'h00020, 9'h001, 1'b0});
        raise(1'b1, 16'h001F, 12'h000, '{1'b1, 17'h0001F, 9'h000, 1'b0});
        #1;
        chk("rstadd_ready", 32'({bus.o_ready1, bus.o_ready0}), 32'd0);
        @(posedge clk); #2;
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 32'({bus.o_ready1, bus.o_ready0}), 32'b01);
        wait_accept(1'b0, "post_rst_accept0");
        wait_accept(1'b1, "post_rst_accept1");
        drain("post_rst_drain");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
